// File: rtl/async_fifo_pkg.sv
// Shared constants for the async FIFO and its read-side streamer.
// Also provides a clog2 helper for parameter-derived widths.
package async_fifo_pkg;

    localparam int DATA_WIDTH    = 16;
    localparam int DATAIN_WIDTH  = 16;
    localparam int DATAOUT_WIDTH = 16;
    localparam int BUF_DEPTH     = 4;
    localparam int BURST_LEN     = 8;

    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/stream_ring_buf.sv
// Power-of-two ring buffer: push writes at wr_ptr, head is always visible on pop_data.
// Zero-latency head; pop on an empty buffer is ignored, push on full must be prevented upstream.
module stream_ring_buf import async_fifo_pkg::clog2; #(
    parameter int DATA_WIDTH = async_fifo_pkg::DATA_WIDTH,
    parameter int DEPTH      = async_fifo_pkg::BUF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_WIDTH-1:0]  push_data,
    input  logic                   pop,
    output logic [DATA_WIDTH-1:0]  pop_data,
    output logic [clog2(DEPTH):0]  occ
);

    localparam int PW = clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  pop_ok;

    assign pop_ok   = pop & (occ != '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push, pop_ok})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_read_streamer.sv
// Drains the async FIFO read port (1-cycle read latency) into a valid/ready stream with m_last framing.
// r_en -> m_valid is 2 cycles; fetch depends only on registered state so m_ready never reaches r_en.
module fifo_read_streamer import async_fifo_pkg::clog2; #(
    parameter int DATA_WIDTH = async_fifo_pkg::DATA_WIDTH,
    parameter int BUF_DEPTH  = async_fifo_pkg::BUF_DEPTH,
    parameter int BURST_LEN  = async_fifo_pkg::BURST_LEN
) (
    input  logic                      r_clk,
    input  logic                      r_rst,
    input  logic                      drain_en,
    input  logic                      flag_empty,
    input  logic [DATA_WIDTH-1:0]     data_read,
    output logic                      r_en,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic                      m_last,
    output logic [clog2(BUF_DEPTH):0] buf_level,
    output logic                      busy
);

    localparam int LW = clog2(BUF_DEPTH) + 1;
    localparam int BW = (BURST_LEN > 1) ? clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [LW:0]   DEPTH_W   = (LW + 1)'(BUF_DEPTH);

    logic                  inflight;
    logic [BW-1:0]         beat_cnt;
    logic [LW-1:0]         occ;
    logic [DATA_WIDTH-1:0] head;
    logic [LW:0]           fill;
    logic                  has_data;
    logic                  pop;

    // Count the in-flight word as occupied so the buffer can never overflow.
    assign fill     = {1'b0, occ} + {{LW{1'b0}}, inflight};
    assign has_data = (occ != '0);
    assign r_en     = ~r_rst & drain_en & ~flag_empty & (fill < DEPTH_W);

    assign m_valid   = ~r_rst & has_data;
    assign m_data    = r_rst ? '0 : head;
    assign m_last    = m_valid & (beat_cnt == LAST_BEAT);
    assign buf_level = r_rst ? '0 : occ;
    assign busy      = ~r_rst & (has_data | inflight);
    assign pop       = m_valid & m_ready;

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            inflight <= 1'b0;
            beat_cnt <= '0;
        end else begin
            inflight <= r_en;
            if (pop) begin
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BW'(1);
            end
        end
    end

    stream_ring_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_ring (
        .clk       (r_clk),
        .rst       (r_rst),
        .push      (inflight),
        .push_data (data_read),
        .pop       (pop),
        .pop_data  (head),
        .occ       (occ)
    );

endmodule
